// File: rtl/keypad_event_controller_if.sv
// Consumer-side event handshake for the keypad event controller.
// master drives out_valid/out_code, slave returns out_ready.
interface keypad_event_if;
  logic       out_valid;
  logic [3:0] out_code;
  logic       out_ready;

  modport master (
    output out_valid,
    output out_code,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_code,
    output out_ready
  );
endinterface

// File: rtl/keypad_event_controller.sv
// Keypad event controller: scan prescaler, press/release debouncer
// and FWFT event FIFO with ready/valid output and sticky overflow.
//
// Ports:
//   clock, reset     system clock, async active-high reset
//   key_valid/code   decoded key from the scanner
//   scan_tick        one-cycle pulse every SCAN_DIV cycles
//   evt              out_valid/out_code/out_ready event handshake
//   fifo_count       queued event count
//   overflow         sticky drop flag, cleared by clear_overflow
module keypad_event_controller #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        key_valid,
  input  logic [3:0]                  key_code,
  output logic                        scan_tick,
  keypad_event_if.master              evt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        clear_overflow
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [7:0]    DEB      = 8'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM,
    HELD,
    RELEASE
  } state_t;

  logic [DW-1:0] div_cnt;

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic [3:0] cand;

  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // prescaler
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      scan_tick <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt   <= '0;
      scan_tick <= 1'b1;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
      scan_tick <= 1'b0;
    end
  end

  assign cnt_inc = cnt + 8'd1;

  // A push is the accepting edge of a press: IDLE when a single
  // sample suffices, else the final matching CONFIRM sample.
  // The pushed code equals key_code in both cases.
  always_comb begin
    push_req = 1'b0;
    if (scan_tick && key_valid) begin
      unique case (state)
        IDLE:    push_req = (DEBOUNCE_CYCLES == 1);
        CONFIRM: push_req = (key_code == cand) &&
                            (cnt_inc >= DEB);
        default: push_req = 1'b0;
      endcase
    end
  end

  // debounce FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else if (scan_tick) begin
      unique case (state)
        IDLE: begin
          if (key_valid) begin
            cand  <= key_code;
            cnt   <= 8'd1;
            state <= (DEBOUNCE_CYCLES == 1) ? HELD : CONFIRM;
          end
        end
        CONFIRM: begin
          if (!key_valid) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (key_code != cand) begin
            cand <= key_code;
            cnt  <= 8'd1;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc >= DEB)
              state <= HELD;
          end
        end
        HELD: begin
          if (!key_valid) begin
            cnt   <= 8'd1;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (key_valid) begin
            state <= HELD;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc >= DEB)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // event FIFO
  assign full    = (fifo_count == FULL_CNT);
  assign pop     = evt.out_valid && evt.out_ready;
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clock) begin
    if (push_ok)
      mem[wr_ptr] <= key_code;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      // a drop on the same edge as a clear keeps the flag set
      if (push_req && !push_ok)
        overflow <= 1'b1;
      else if (clear_overflow)
        overflow <= 1'b0;
    end
  end

  // stale storage is masked so the code reads 0 while empty
  assign evt.out_valid = (fifo_count != '0);
  assign evt.out_code  = evt.out_valid ? mem[rd_ptr] : 4'h0;

endmodule
